ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of core_lapido. Sits directly downstream of the decode stage and consumes its registered outputs (alu funct, mux selects, control bits, operands, immediate, next pc).
- Performs ALU operation with operand forwarding and keeps the architectural flag register.
- Resolves BEQ/BNE/JT/JF and drives branch_taken/branch_addr back to fetch.
- Registers results into the EX/MEM pipeline register.

Parameters:
- GPR_WIDTH, 32, datapath width.
- PC_WIDTH, 32, pc width; pc is word-addressed (+1 per instruction).
- NUM_FLAGS, 6, width of flag register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_funct  in  6  FN_* code from decode.
- alu_src_mux  in  1  0: operand B = rt path; 1: B = imm.
- reg_dst_mux  in  2  0: rd; 1: rt; 2: rs field (JAL link reg); 3: rd.
- is_load, fl_write_enable, mem_write_enable, reg_write_enable  in  1 each  control from decode.
- is_branch, sel_beq_bne, sel_jt_jf, sel_jflag_branch  in  1 each  branch control.
- wb_res_mux  in  2  passed through.
- rs, rt, rd  in  5 each  register fields; rs doubles as flag code for JT/JF.
- imm  in  GPR_WIDTH  sign-extended immediate.
- next_pc  in  PC_WIDTH  pc+1 of instruction in EX.
- data_rs, data_rt  in  GPR_WIDTH  register operands.
- fwd_sel_a, fwd_sel_b  in  2 each  0: decode data; 1: mem_fwd_data; 2: wb_fwd_data; 3: decode data.
- mem_fwd_data, wb_fwd_data  in  GPR_WIDTH  forwarded values.
- branch_taken  out  1  combinational, to fetch.
- branch_addr  out  PC_WIDTH  combinational, to fetch.
- flush_id  out  1  equals branch_taken; decode must squash its register.
- flags  out  NUM_FLAGS  current flag register.
- out_alu_result, out_store_data  out  GPR_WIDTH  registered.
- out_dst  out  5  registered destination register.
- out_next_pc  out  PC_WIDTH  registered (JAL link value).
- out_is_load, out_mem_write_enable, out_reg_write_enable  out  1 each  registered.
- out_wb_res_mux  out  2  registered.

Behaviour:
- Reset (rst=0, asynchronous): every out_* register and flags go to 0; combinational outputs follow from the zeroed state.
- Operand A = fwd mux(data_rs). Operand R = fwd mux(data_rt). B = alu_src_mux ? imm : R. out_store_data = R.
- ALU (32-bit, combinational):
  - ADD/SUB: A±B, using 33-bit internal sum; SUB is A+~B+1.
  - AND/OR/XOR/NOR/XNOR/NAND: bitwise.
  - NOT: ~A.
  - LSL/ASL: A<<1. LSR: A>>1 logical. ASR: A>>1 arithmetic.
  - SLT: signed A<B ? 1 : 0.
  - Any other code: B (pass-through, used by LCL/LCH/LOADLIT).
- Flag bits:
  - [0] always 1.
  - [1] overflow: signed overflow on ADD/SUB; sign change on ASL; else 0.
  - [2] carry: bit 32 on ADD/SUB; shifted-out bit on shifts; else 0.
  - [3] negative: result[31].
  - [4] zero: result==0.
  - [5] neg-or-zero.
- Flag register: written at the rising edge only when fl_write_enable=1. flags[0] is held at 1 after the first write; reset value is 0.
- Branch condition (valid only when is_branch=1, else branch_taken=0):
  - sel_jflag_branch=0: compare A==R; sel_beq_bne=0 takes on equal, 1 takes on not-equal.
  - sel_jflag_branch=1: bit = flags[rs[2:0]]; codes 6 and 7 read 0. sel_jt_jf=0 takes when bit=1, 1 takes when bit=0.
  - JT/JF use the registered flags, i.e. the value before any same-cycle write.
- branch_addr = next_pc + imm[PC_WIDTH-1:0], modulo 2^PC_WIDTH (wraps).
- Pipeline register: latency 1 cycle, no stall input; EX/MEM captures every cycle. A bubble from decode arrives as all-zero control and propagates as such.
- A taken branch does not suppress its own EX/MEM entry; its write-enables are already 0 from decode.
- Reset asserted mid-operation clears registers immediately; no partial state survives.

Test Plan:
- Reset: rst=0 with random inputs -> all out_*=0, flags=0. Release rst; ADD A=5 B=3, fl_we=1 -> next edge out_alu_result=8, flags=6'b000001.
- Flags: SUB A=3 B=3 -> result 0, flags=6'b110101. ADD A=32'h7FFFFFFF B=1 -> result 32'h80000000, flags[1]=1, flags[3]=1, flags[5]=1.
- Forwarding: data_rs=2, mem_fwd_data=100, fwd_sel_a=1, ADD imm=4, alu_src=1 -> result 104. fwd_sel_a=2, wb_fwd_data=7 -> result 11.
- BEQ/BNE: is_branch=1, A=R=9, sel_beq_bne=0, next_pc=20, imm=-5 -> branch_taken=1, branch_addr=15, flush_id=1. Same with sel_beq_bne=1 -> taken=0.
- JT/JF: after SUB 3-3, JT rs=4 -> taken. JF rs=4 -> not taken. JT rs=6 -> not taken. Same-cycle SUB with fl_we and JT -> uses old flags.
- Shifts/dst: ASR A=32'h80000001 -> 32'hC0000000, carry=1. reg_dst_mux=2, rs=1 -> out_dst=1. next_pc=34 -> out_next_pc=34.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of core_lapido.
// Selects forwarded operands, runs the ALU and keeps the architectural flag
// register. It also resolves BEQ/BNE/JT/JF for fetch and captures the results
// into the EX/MEM pipeline register.
//
// Handshake: there is no valid/ready pair. EX/MEM captures every cycle. A
// bubble from decode arrives with all control bits at zero and is carried
// through as such. branch_taken/branch_addr/flush_id are combinational and
// are meaningful in the same cycle as the instruction in EX.
//
// ALU function encoding, shared with decode:
//   0 ADD  1 SUB  2 AND  3 OR   4 XOR  5 NOR  6 XNOR 7 NAND
//   8 NOT  9 LSL 10 ASL 11 LSR 12 ASR 13 SLT  others: pass B
// Flag layout (NUM_FLAGS is expected to be 6):
//   [0] one  [1] overflow  [2] carry  [3] negative  [4] zero  [5] neg|zero
module ex_stage #(
  parameter int GPR_WIDTH = 32,
  parameter int PC_WIDTH  = 32,
  parameter int NUM_FLAGS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           alu_funct,
  input  logic                 alu_src_mux,
  input  logic [1:0]           reg_dst_mux,
  input  logic                 is_load,
  input  logic                 fl_write_enable,
  input  logic                 mem_write_enable,
  input  logic                 reg_write_enable,
  input  logic                 is_branch,
  input  logic                 sel_beq_bne,
  input  logic                 sel_jt_jf,
  input  logic                 sel_jflag_branch,
  input  logic [1:0]           wb_res_mux,
  input  logic [4:0]           rs,
  input  logic [4:0]           rt,
  input  logic [4:0]           rd,
  input  logic [GPR_WIDTH-1:0] imm,
  input  logic [PC_WIDTH-1:0]  next_pc,
  input  logic [GPR_WIDTH-1:0] data_rs,
  input  logic [GPR_WIDTH-1:0] data_rt,
  input  logic [1:0]           fwd_sel_a,
  input  logic [1:0]           fwd_sel_b,
  input  logic [GPR_WIDTH-1:0] mem_fwd_data,
  input  logic [GPR_WIDTH-1:0] wb_fwd_data,
  output logic                 branch_taken,
  output logic [PC_WIDTH-1:0]  branch_addr,
  output logic                 flush_id,
  output logic [NUM_FLAGS-1:0] flags,
  output logic [GPR_WIDTH-1:0] out_alu_result,
  output logic [GPR_WIDTH-1:0] out_store_data,
  output logic [4:0]           out_dst,
  output logic [PC_WIDTH-1:0]  out_next_pc,
  output logic                 out_is_load,
  output logic                 out_mem_write_enable,
  output logic                 out_reg_write_enable,
  output logic [1:0]           out_wb_res_mux
);

  localparam logic [5:0] FN_ADD  = 6'd0;
  localparam logic [5:0] FN_SUB  = 6'd1;
  localparam logic [5:0] FN_AND  = 6'd2;
  localparam logic [5:0] FN_OR   = 6'd3;
  localparam logic [5:0] FN_XOR  = 6'd4;
  localparam logic [5:0] FN_NOR  = 6'd5;
  localparam logic [5:0] FN_XNOR = 6'd6;
  localparam logic [5:0] FN_NAND = 6'd7;
  localparam logic [5:0] FN_NOT  = 6'd8;
  localparam logic [5:0] FN_LSL  = 6'd9;
  localparam logic [5:0] FN_ASL  = 6'd10;
  localparam logic [5:0] FN_LSR  = 6'd11;
  localparam logic [5:0] FN_ASR  = 6'd12;
  localparam logic [5:0] FN_SLT  = 6'd13;

  localparam int MSB = GPR_WIDTH - 1;

  logic [GPR_WIDTH-1:0] op_a;
  logic [GPR_WIDTH-1:0] op_r;
  logic [GPR_WIDTH-1:0] op_b;
  logic [GPR_WIDTH-1:0] addend;
  logic [GPR_WIDTH:0]   sum_ext;
  logic                 is_sub;
  logic [GPR_WIDTH-1:0] alu_res;
  logic                 alu_ovf;
  logic                 alu_carry;
  logic [NUM_FLAGS-1:0] new_flags;
  logic [7:0]           flag_pad;
  logic                 flag_bit;
  logic [4:0]           dst_sel;

  // Forwarding muxes for both register operands, then the immediate select.
  always_comb begin
    case (fwd_sel_a)
      2'd1:    op_a = mem_fwd_data;
      2'd2:    op_a = wb_fwd_data;
      default: op_a = data_rs;
    endcase
    case (fwd_sel_b)
      2'd1:    op_r = mem_fwd_data;
      2'd2:    op_r = wb_fwd_data;
      default: op_r = data_rt;
    endcase
    op_b = alu_src_mux ? imm : op_r;
  end

  // Shared adder: SUB is A + ~B + 1, so carry is "no borrow".
  always_comb begin
    is_sub  = (alu_funct == FN_SUB);
    addend  = is_sub ? ~op_b : op_b;
    sum_ext = {1'b0, op_a} + {1'b0, addend} + {{GPR_WIDTH{1'b0}}, is_sub};
  end

  // ALU result plus the overflow/carry side outputs of each operation.
  always_comb begin
    alu_res   = op_b;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    case (alu_funct)
      FN_ADD, FN_SUB: begin
        alu_res   = sum_ext[MSB:0];
        alu_ovf   = (op_a[MSB] == addend[MSB]) && (sum_ext[MSB] != op_a[MSB]);
        alu_carry = sum_ext[GPR_WIDTH];
      end
      FN_AND:  alu_res = op_a & op_b;
      FN_OR:   alu_res = op_a | op_b;
      FN_XOR:  alu_res = op_a ^ op_b;
      FN_NOR:  alu_res = ~(op_a | op_b);
      FN_XNOR: alu_res = ~(op_a ^ op_b);
      FN_NAND: alu_res = ~(op_a & op_b);
      FN_NOT:  alu_res = ~op_a;
      FN_LSL: begin
        alu_res   = op_a << 1;
        alu_carry = op_a[MSB];
      end
      FN_ASL: begin
        alu_res   = op_a << 1;
        alu_carry = op_a[MSB];
        alu_ovf   = op_a[MSB] ^ op_a[MSB-1];
      end
      FN_LSR: begin
        alu_res   = op_a >> 1;
        alu_carry = op_a[0];
      end
      FN_ASR: begin
        alu_res   = $unsigned($signed(op_a) >>> 1);
        alu_carry = op_a[0];
      end
      FN_SLT:  alu_res = {{(GPR_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = op_b;
    endcase
  end

  // Flag vector that a flag-writing instruction would commit.
  always_comb begin
    new_flags    = '0;
    new_flags[0] = 1'b1;
    new_flags[1] = alu_ovf;
    new_flags[2] = alu_carry;
    new_flags[3] = alu_res[MSB];
    new_flags[4] = (alu_res == '0);
    new_flags[5] = alu_res[MSB] | (alu_res == '0);
  end

  // Branch resolution; JT/JF read the registered flags (pre-write value).
  always_comb begin
    flag_pad = {{(8-NUM_FLAGS){1'b0}}, flags};
    flag_bit = flag_pad[rs[2:0]];
    branch_taken = 1'b0;
    if (is_branch) begin
      if (sel_jflag_branch)
        branch_taken = sel_jt_jf ? ~flag_bit : flag_bit;
      else
        branch_taken = sel_beq_bne ? (op_a != op_r) : (op_a == op_r);
    end
    branch_addr = next_pc + imm[PC_WIDTH-1:0];
    flush_id    = branch_taken;
  end

  // Destination register select; code 2 links into the rs field for JAL.
  always_comb begin
    case (reg_dst_mux)
      2'd1:    dst_sel = rt;
      2'd2:    dst_sel = rs;
      default: dst_sel = rd;
    endcase
  end

  // Architectural flag register, written only by flag-setting instructions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flags <= '0;
    else if (fl_write_enable)
      flags <= new_flags;
  end

  // EX/MEM pipeline register, captured every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_alu_result       <= '0;
      out_store_data       <= '0;
      out_dst              <= '0;
      out_next_pc          <= '0;
      out_is_load          <= 1'b0;
      out_mem_write_enable <= 1'b0;
      out_reg_write_enable <= 1'b0;
      out_wb_res_mux       <= 2'd0;
    end else begin
      out_alu_result       <= alu_res;
      out_store_data       <= op_r;
      out_dst              <= dst_sel;
      out_next_pc          <= next_pc;
      out_is_load          <= is_load;
      out_mem_write_enable <= mem_write_enable;
      out_reg_write_enable <= reg_write_enable;
      out_wb_res_mux       <= wb_res_mux;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed scenarios followed by randomized
// instructions checked against an arithmetic reference model.
module tb_ex_stage;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_OR  = 6'd3;
  localparam logic [5:0] FN_XOR = 6'd4;
  localparam logic [5:0] FN_NOR = 6'd5;
  localparam logic [5:0] FN_XNOR = 6'd6;
  localparam logic [5:0] FN_NAND = 6'd7;
  localparam logic [5:0] FN_NOT = 6'd8;
  localparam logic [5:0] FN_LSL = 6'd9;
  localparam logic [5:0] FN_ASL = 6'd10;
  localparam logic [5:0] FN_LSR = 6'd11;
  localparam logic [5:0] FN_ASR = 6'd12;
  localparam logic [5:0] FN_SLT = 6'd13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  alu_funct;
  logic        alu_src_mux;
  logic [1:0]  reg_dst_mux;
  logic        is_load, fl_write_enable, mem_write_enable, reg_write_enable;
  logic        is_branch, sel_beq_bne, sel_jt_jf, sel_jflag_branch;
  logic [1:0]  wb_res_mux;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, next_pc, data_rs, data_rt, mem_fwd_data, wb_fwd_data;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        branch_taken, flush_id;
  logic [31:0] branch_addr;
  logic [5:0]  flags;
  logic [31:0] out_alu_result, out_store_data, out_next_pc;
  logic [4:0]  out_dst;
  logic        out_is_load, out_mem_write_enable, out_reg_write_enable;
  logic [1:0]  out_wb_res_mux;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] m_flags = 6'd0;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .alu_funct(alu_funct), .alu_src_mux(alu_src_mux), .reg_dst_mux(reg_dst_mux),
    .is_load(is_load), .fl_write_enable(fl_write_enable),
    .mem_write_enable(mem_write_enable), .reg_write_enable(reg_write_enable),
    .is_branch(is_branch), .sel_beq_bne(sel_beq_bne), .sel_jt_jf(sel_jt_jf),
    .sel_jflag_branch(sel_jflag_branch), .wb_res_mux(wb_res_mux),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .next_pc(next_pc),
    .data_rs(data_rs), .data_rt(data_rt),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .flush_id(flush_id),
    .flags(flags), .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_dst(out_dst), .out_next_pc(out_next_pc), .out_is_load(out_is_load),
    .out_mem_write_enable(out_mem_write_enable),
    .out_reg_write_enable(out_reg_write_enable), .out_wb_res_mux(out_wb_res_mux)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_pick(input logic [1:0] sel,
      input logic [31:0] dec, input logic [31:0] mem, input logic [31:0] wb);
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return wb;
    return dec;
  endfunction

  task automatic model_alu(input logic [5:0] f, input logic [31:0] a,
      input logic [31:0] b, output logic [31:0] r, output logic [5:0] fl);
    longint sa, sb, s;
    logic ovf, c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 1'b0;
    c = 1'b0;
    case (f)
      FN_ADD: begin
        r = a + b; s = sa + sb;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        c = (longint'(a) + longint'(b)) > 64'sd4294967295;
      end
      FN_SUB: begin
        r = a - b; s = sa - sb;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        c = (a >= b);
      end
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      FN_NOR:  r = ~(a | b);
      FN_XNOR: r = ~(a ^ b);
      FN_NAND: r = ~(a & b);
      FN_NOT:  r = ~a;
      FN_LSL:  begin r = a * 2; c = a[31]; end
      FN_ASL:  begin r = a * 2; c = a[31]; ovf = (r[31] != a[31]); end
      FN_LSR:  begin r = a / 2; c = a[0]; end
      FN_ASR:  begin r = {a[31], a[31:1]}; c = a[0]; end
      FN_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = b;
    endcase
    fl = {r[31] || (r == 32'd0), r == 32'd0, r[31], c, ovf, 1'b1};
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    alu_funct = 6'd0; alu_src_mux = 1'b0; reg_dst_mux = 2'd0;
    is_load = 1'b0; fl_write_enable = 1'b0; mem_write_enable = 1'b0;
    reg_write_enable = 1'b0; is_branch = 1'b0; sel_beq_bne = 1'b0;
    sel_jt_jf = 1'b0; sel_jflag_branch = 1'b0; wb_res_mux = 2'd0;
    rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 32'd0; next_pc = 32'd0;
    data_rs = 32'd0; data_rt = 32'd0; fwd_sel_a = 2'd0; fwd_sel_b = 2'd0;
    mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
  endtask

  task automatic randomize_inputs();
    alu_funct = 6'($urandom_range(0, 20)); alu_src_mux = 1'($urandom);
    reg_dst_mux = 2'($urandom); is_load = 1'($urandom);
    fl_write_enable = 1'($urandom); mem_write_enable = 1'($urandom);
    reg_write_enable = 1'($urandom); is_branch = 1'($urandom);
    sel_beq_bne = 1'($urandom); sel_jt_jf = 1'($urandom);
    sel_jflag_branch = 1'($urandom); wb_res_mux = 2'($urandom);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = $urandom; next_pc = $urandom; data_rs = $urandom; data_rt = $urandom;
    fwd_sel_a = 2'($urandom); fwd_sel_b = 2'($urandom);
    mem_fwd_data = $urandom; wb_fwd_data = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      data_rt = data_rs; fwd_sel_b = fwd_sel_a;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    randomize_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_alu_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h exp 0", out_alu_result); end
    n_tests++; if (out_store_data !== 32'd0) begin n_fail++; $display("FAIL reset_store got %h exp 0", out_store_data); end
    n_tests++; if ({out_dst, out_next_pc} !== 37'd0) begin n_fail++; $display("FAIL reset_dst_pc got %h/%h exp 0", out_dst, out_next_pc); end
    n_tests++; if ({out_is_load, out_mem_write_enable, out_reg_write_enable, out_wb_res_mux} !== 5'd0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0", {out_is_load, out_mem_write_enable, out_reg_write_enable, out_wb_res_mux}); end
    n_tests++; if (flags !== 6'd0) begin n_fail++; $display("FAIL reset_flags got %b exp 000000", flags); end
    clear_inputs();
    rst = 1'b1;
    m_flags = 6'd0;
  endtask

  task automatic test_add_basic();
    clear_inputs();
    alu_funct = FN_ADD; data_rs = 32'd5; imm = 32'd3; alu_src_mux = 1'b1;
    fl_write_enable = 1'b1;
    step();
    n_tests++; if (out_alu_result !== 32'd8) begin n_fail++; $display("FAIL add_result got %h exp 8", out_alu_result); end
    n_tests++; if (flags !== 6'b000001) begin n_fail++; $display("FAIL add_flags got %b exp 000001", flags); end
    m_flags = 6'b000001;
  endtask

  task automatic test_flags();
    clear_inputs();
    alu_funct = FN_SUB; data_rs = 32'd3; data_rt = 32'd3; fl_write_enable = 1'b1;
    step();
    n_tests++; if (out_alu_result !== 32'd0) begin n_fail++; $display("FAIL sub_result got %h exp 0", out_alu_result); end
    n_tests++; if (flags !== 6'b110101) begin n_fail++; $display("FAIL sub_flags got %b exp 110101", flags); end
    alu_funct = FN_ADD; data_rs = 32'h7FFFFFFF; data_rt = 32'd1;
    step();
    n_tests++; if (out_alu_result !== 32'h80000000) begin n_fail++; $display("FAIL ovf_result got %h exp 80000000", out_alu_result); end
    n_tests++; if (flags !== 6'b101011) begin n_fail++; $display("FAIL ovf_flags got %b exp 101011", flags); end
    fl_write_enable = 1'b0; alu_funct = FN_SUB; data_rs = 32'd0; data_rt = 32'd0;
    step();
    n_tests++; if (flags !== 6'b101011) begin n_fail++; $display("FAIL flags_hold got %b exp 101011", flags); end
    m_flags = 6'b101011;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    alu_funct = FN_ADD; data_rs = 32'd2; mem_fwd_data = 32'd100; fwd_sel_a = 2'd1;
    imm = 32'd4; alu_src_mux = 1'b1;
    step();
    n_tests++; if (out_alu_result !== 32'd104) begin n_fail++; $display("FAIL fwd_mem got %0d exp 104", out_alu_result); end
    fwd_sel_a = 2'd2; wb_fwd_data = 32'd7;
    step();
    n_tests++; if (out_alu_result !== 32'd11) begin n_fail++; $display("FAIL fwd_wb got %0d exp 11", out_alu_result); end
    data_rt = 32'd55; fwd_sel_b = 2'd1;
    step();
    n_tests++; if (out_store_data !== 32'd100) begin n_fail++; $display("FAIL fwd_store_mem got %0d exp 100", out_store_data); end
    fwd_sel_b = 2'd3;
    step();
    n_tests++; if (out_store_data !== 32'd55) begin n_fail++; $display("FAIL fwd_store_dec got %0d exp 55", out_store_data); end
  endtask

  task automatic test_branch_eq();
    clear_inputs();
    is_branch = 1'b1; data_rs = 32'd9; data_rt = 32'd9; next_pc = 32'd20;
    imm = 32'hFFFFFFFB;
    #1;
    n_tests++; if ({branch_taken, flush_id} !== 2'b11) begin n_fail++; $display("FAIL beq_taken got %b exp 11", {branch_taken, flush_id}); end
    n_tests++; if (branch_addr !== 32'd15) begin n_fail++; $display("FAIL beq_addr got %0d exp 15", branch_addr); end
    sel_beq_bne = 1'b1;
    #1;
    n_tests++; if ({branch_taken, flush_id} !== 2'b00) begin n_fail++; $display("FAIL bne_equal got %b exp 00", {branch_taken, flush_id}); end
    data_rt = 32'd10;
    #1;
    n_tests++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL bne_diff got %b exp 1", branch_taken); end
    next_pc = 32'hFFFFFFFF; imm = 32'd2;
    #1;
    n_tests++; if (branch_addr !== 32'd1) begin n_fail++; $display("FAIL addr_wrap got %h exp 1", branch_addr); end
    is_branch = 1'b0;
    #1;
    n_tests++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL not_branch got %b exp 0", branch_taken); end
    step();
  endtask

  task automatic test_jt_jf();
    clear_inputs();
    alu_funct = FN_SUB; data_rs = 32'd3; data_rt = 32'd3; fl_write_enable = 1'b1;
    step();
    clear_inputs();
    is_branch = 1'b1; sel_jflag_branch = 1'b1; rs = 5'd4;
    #1;
    n_tests++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL jt_zero got %b exp 1", branch_taken); end
    sel_jt_jf = 1'b1;
    #1;
    n_tests++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL jf_zero got %b exp 0", branch_taken); end
    sel_jt_jf = 1'b0; rs = 5'd6;
    #1;
    n_tests++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL jt_code6 got %b exp 0", branch_taken); end
    sel_jt_jf = 1'b1; rs = 5'd7;
    #1;
    n_tests++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL jf_code7 got %b exp 1", branch_taken); end
    step();
    // Make zero flag 0, then SUB 3-3 with JT on zero in the same cycle.
    clear_inputs();
    alu_funct = FN_ADD; data_rs = 32'd5; data_rt = 32'd3; fl_write_enable = 1'b1;
    step();
    alu_funct = FN_SUB; data_rs = 32'd3; data_rt = 32'd3;
    is_branch = 1'b1; sel_jflag_branch = 1'b1; rs = 5'd4;
    #1;
    n_tests++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL jt_old_flags got %b exp 0", branch_taken); end
    step();
    n_tests++; if (flags !== 6'b110101) begin n_fail++; $display("FAIL jt_after_write got %b exp 110101", flags); end
    n_tests++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL jt_new_flags got %b exp 1", branch_taken); end
    m_flags = 6'b110101;
  endtask

  task automatic test_shift_dst();
    clear_inputs();
    alu_funct = FN_ASR; data_rs = 32'h80000001; fl_write_enable = 1'b1;
    reg_dst_mux = 2'd2; rs = 5'd1; rt = 5'd5; rd = 5'd9; next_pc = 32'd34;
    step();
    n_tests++; if (out_alu_result !== 32'hC0000000) begin n_fail++; $display("FAIL asr_result got %h exp c0000000", out_alu_result); end
    n_tests++; if (flags !== 6'b101101) begin n_fail++; $display("FAIL asr_flags got %b exp 101101", flags); end
    n_tests++; if (out_dst !== 5'd1) begin n_fail++; $display("FAIL dst_rs got %0d exp 1", out_dst); end
    n_tests++; if (out_next_pc !== 32'd34) begin n_fail++; $display("FAIL next_pc got %0d exp 34", out_next_pc); end
    alu_funct = FN_ASL; data_rs = 32'h40000000; reg_dst_mux = 2'd1;
    step();
    n_tests++; if ({out_alu_result, flags} !== {32'h80000000, 6'b101011}) begin
      n_fail++; $display("FAIL asl_ovf got %h/%b exp 80000000/101011", out_alu_result, flags); end
    n_tests++; if (out_dst !== 5'd5) begin n_fail++; $display("FAIL dst_rt got %0d exp 5", out_dst); end
    m_flags = 6'b101011;
  endtask

  task automatic test_random();
    logic [31:0] a, r, b, e_res;
    logic [5:0]  e_fl;
    logic        fb, e_taken;
    logic [4:0]  e_dst;
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      #1;
      a = fwd_pick(fwd_sel_a, data_rs, mem_fwd_data, wb_fwd_data);
      r = fwd_pick(fwd_sel_b, data_rt, mem_fwd_data, wb_fwd_data);
      b = alu_src_mux ? imm : r;
      model_alu(alu_funct, a, b, e_res, e_fl);
      fb = (rs[2:0] < 3'd6) ? m_flags[rs[2:0]] : 1'b0;
      if (!is_branch) e_taken = 1'b0;
      else if (sel_jflag_branch) e_taken = sel_jt_jf ? !fb : fb;
      else e_taken = sel_beq_bne ? (a != r) : (a == r);
      e_dst = (reg_dst_mux == 2'd1) ? rt : (reg_dst_mux == 2'd2) ? rs : rd;
      n_tests++; if ({branch_taken, flush_id} !== {e_taken, e_taken}) begin
        n_fail++; $display("FAIL rnd_taken[%0d] got %b exp %b", i, {branch_taken, flush_id}, {e_taken, e_taken}); end
      n_tests++; if (branch_addr !== next_pc + imm) begin
        n_fail++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, branch_addr, next_pc + imm); end
      step();
      if (fl_write_enable) m_flags = e_fl;
      n_tests++; if (out_alu_result !== e_res) begin
        n_fail++; $display("FAIL rnd_result[%0d] fn %0d got %h exp %h", i, alu_funct, out_alu_result, e_res); end
      n_tests++; if (flags !== m_flags) begin
        n_fail++; $display("FAIL rnd_flags[%0d] fn %0d got %b exp %b", i, alu_funct, flags, m_flags); end
      n_tests++; if ({out_store_data, out_dst, out_next_pc} !== {r, e_dst, next_pc}) begin
        n_fail++; $display("FAIL rnd_pipe[%0d] got %h/%0d/%h exp %h/%0d/%h", i, out_store_data, out_dst, out_next_pc, r, e_dst, next_pc); end
      n_tests++; if ({out_is_load, out_mem_write_enable, out_reg_write_enable, out_wb_res_mux} !==
                     {is_load, mem_write_enable, reg_write_enable, wb_res_mux}) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d] got %b exp %b", i,
          {out_is_load, out_mem_write_enable, out_reg_write_enable, out_wb_res_mux},
          {is_load, mem_write_enable, reg_write_enable, wb_res_mux}); end
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    alu_funct = FN_OR; data_rs = 32'h00F0F0F0; data_rt = 32'h0F000001; fl_write_enable = 1'b1;
    reg_write_enable = 1'b1; is_load = 1'b1; wb_res_mux = 2'd3; rd = 5'd12; next_pc = 32'd77;
    step();
    n_tests++; if (out_alu_result !== 32'h0FF0F0F1) begin n_fail++; $display("FAIL or_result got %h exp 0ff0f0f1", out_alu_result); end
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if ({out_alu_result, out_store_data, out_next_pc} !== 96'd0) begin
      n_fail++; $display("FAIL midrst_data got %h/%h/%h exp 0", out_alu_result, out_store_data, out_next_pc); end
    n_tests++; if ({out_dst, out_is_load, out_mem_write_enable, out_reg_write_enable, out_wb_res_mux, flags} !== 16'd0) begin
      n_fail++; $display("FAIL midrst_ctrl got %b exp 0",
        {out_dst, out_is_load, out_mem_write_enable, out_reg_write_enable, out_wb_res_mux, flags}); end
    step();
    rst = 1'b1;
    m_flags = 6'd0;
    clear_inputs();
    step();
    n_tests++; if ({out_alu_result, out_reg_write_enable, flags} !== 39'd0) begin
      n_fail++; $display("FAIL bubble got %h/%b/%b exp 0", out_alu_result, out_reg_write_enable, flags); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_add_basic();
    test_flags();
    test_forwarding();
    test_branch_eq();
    test_jt_jf();
    test_shift_dst();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
